// File: rtl/dt_pkg.sv
// Shared constants, FSM encoding and address helper for the distance-map peak scanner.
package dt_pkg;

    localparam int IMG_W   = 128;
    localparam int ADDR_W  = 14;
    localparam int COORD_W = 7;
    localparam int PIX_W   = 8;
    localparam int CNT_W   = 15;
    localparam int RD_LAT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] make_addr(input logic [COORD_W-1:0] row,
                                                    input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/dt_stat_accum.sv
// Running statistics over a raster stream of pixels: peak value, first peak location,
// peak multiplicity and non-zero area.
module dt_stat_accum
    import dt_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               valid,
    input  logic [PIX_W-1:0]   pixel,
    input  logic [COORD_W-1:0] row,
    input  logic [COORD_W-1:0] col,
    output logic [PIX_W-1:0]   max_val,
    output logic [COORD_W-1:0] max_row,
    output logic [COORD_W-1:0] max_col,
    output logic [CNT_W-1:0]   max_cnt,
    output logic [CNT_W-1:0]   area
);

    logic first;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            first   <= 1'b0;
            max_val <= '0;
            max_row <= '0;
            max_col <= '0;
            max_cnt <= '0;
            area    <= '0;
        end else if (clear) begin
            first   <= 1'b1;
            max_val <= '0;
            max_row <= '0;
            max_col <= '0;
            max_cnt <= '0;
            area    <= '0;
        end else if (valid) begin
            first <= 1'b0;
            // The first sample always seeds the peak so an all-zero map still counts every pixel.
            if (first || (pixel > max_val)) begin
                max_val <= pixel;
                max_row <= row;
                max_col <= col;
                max_cnt <= CNT_W'(1);
            end else if (pixel == max_val) begin
                max_cnt <= max_cnt + CNT_W'(1);
            end
            if (pixel != '0) begin
                area <= area + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dt_peak_scan.sv
// Raster scan of the distance map in the shared result RAM, feeding the statistics
// accumulator once each read has come back.
module dt_peak_scan
    import dt_pkg::*;
#(
    parameter int IMG_W  = dt_pkg::IMG_W,
    parameter int RD_LAT = dt_pkg::RD_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               res_rd,
    output logic [ADDR_W-1:0]  res_addr,
    input  logic [PIX_W-1:0]   res_di,
    output logic [PIX_W-1:0]   max_val,
    output logic [COORD_W-1:0] max_row,
    output logic [COORD_W-1:0] max_col,
    output logic [CNT_W-1:0]   max_cnt,
    output logic [CNT_W-1:0]   area
);

    localparam int PIPE = RD_LAT - 1;
    localparam logic [COORD_W-1:0] LAST_C = COORD_W'(IMG_W - 1);

    state_t state, state_nxt;
    logic [COORD_W-1:0] row_q, col_q;
    logic               clear, last_addr;
    logic [PIPE-1:0]    vld_pipe;
    logic [ADDR_W-1:0]  tag_pipe [PIPE];
    logic               vld_p1;
    logic [ADDR_W-1:0]  tag_p1;

    assign clear     = (state == IDLE) && start;
    assign last_addr = (row_q == LAST_C) && (col_q == LAST_C);
    assign res_addr  = make_addr(row_q, col_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = SCAN;
            SCAN:    if (last_addr)  state_nxt = DRAIN;
            DRAIN:   if (~|vld_pipe) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        res_rd = (state == SCAN);
        busy   = (state == SCAN) || (state == DRAIN);
        done   = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clear) begin
            row_q <= '0;
            col_q <= '0;
        end else if (state == SCAN) begin
            if (col_q == LAST_C) begin
                col_q <= '0;
                row_q <= (row_q == LAST_C) ? '0 : row_q + COORD_W'(1);
            end else begin
                col_q <= col_q + COORD_W'(1);
            end
        end
    end

    // ---- read pipeline: address registered -> data sampled RD_LAT edges later ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= res_rd;
            for (int i = 1; i < PIPE; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_pipe[0] <= res_addr;
        for (int i = 1; i < PIPE; i++) tag_pipe[i] <= tag_pipe[i-1];
    end

    assign vld_p1 = vld_pipe[PIPE-1];
    assign tag_p1 = tag_pipe[PIPE-1];

    dt_stat_accum u_accum (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .valid   (vld_p1),
        .pixel   (res_di),
        .row     (tag_p1[ADDR_W-1 -: COORD_W]),
        .col     (tag_p1[COORD_W-1:0]),
        .max_val (max_val),
        .max_row (max_row),
        .max_col (max_col),
        .max_cnt (max_cnt),
        .area    (area)
    );

endmodule

// File: tb/tb_dt_peak_scan.sv
// Bench for dt_peak_scan: result RAM model with registered read, map statistics
// computed directly from the stored image.
module tb_dt_peak_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di = 8'd0;
    logic [7:0]  max_val;
    logic [6:0]  max_row, max_col;
    logic [14:0] max_cnt, area;

    logic [7:0]  mem [16384];

    int vectors = 0;
    int miscompares = 0;
    int rd_cycles = 0;
    int addr_err = 0;
    int done_pulses = 0;
    logic [13:0] prev_addr = 14'd0;
    int exp_val, exp_row, exp_col, exp_cnt, exp_area;
    int cyc;

    dt_peak_scan dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .max_val  (max_val),
        .max_row  (max_row),
        .max_col  (max_col),
        .max_cnt  (max_cnt),
        .area     (area)
    );

    always #5 clk = ~clk;

    // RAM with one output register: address from edge k appears on res_di after edge k+1.
    always @(posedge clk) begin
        if (res_rd) res_di <= mem[res_addr];
    end

    always @(negedge clk) begin
        if (done) done_pulses <= done_pulses + 1;
        if (res_rd) begin
            rd_cycles <= rd_cycles + 1;
            if (int'(res_addr) != ((rd_cycles == 0) ? 0 : int'(prev_addr) + 1))
                addr_err <= addr_err + 1;
            prev_addr <= res_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        int first_idx;
        exp_val = 0; exp_cnt = 0; exp_area = 0; first_idx = -1;
        for (int i = 0; i < 16384; i++)
            if (int'(mem[i]) > exp_val) exp_val = int'(mem[i]);
        for (int i = 0; i < 16384; i++) begin
            if (int'(mem[i]) == exp_val) begin
                exp_cnt++;
                if (first_idx < 0) first_idx = i;
            end
            if (mem[i] != 8'd0) exp_area++;
        end
        exp_row = first_idx / 128;
        exp_col = first_idx % 128;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    endtask

    task automatic start_scan();
        @(negedge clk);
        start = 1'b1;
        rd_cycles = 0;
        addr_err = 0;
        done_pulses = 0;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 20000) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
    endtask

    task automatic check_results(input string pfx);
        check({pfx, " max_val"}, 32'(max_val), 32'(exp_val));
        check({pfx, " max_row"}, 32'(max_row), 32'(exp_row));
        check({pfx, " max_col"}, 32'(max_col), 32'(exp_col));
        check({pfx, " max_cnt"}, 32'(max_cnt), 32'(exp_cnt));
        check({pfx, " area"},    32'(area),    32'(exp_area));
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, " busy"},     32'(busy),     32'd0);
        check({pfx, " done"},     32'(done),     32'd0);
        check({pfx, " res_rd"},   32'(res_rd),   32'd0);
        check({pfx, " res_addr"}, 32'(res_addr), 32'd0);
        check({pfx, " max_val"},  32'(max_val),  32'd0);
        check({pfx, " max_row"},  32'(max_row),  32'd0);
        check({pfx, " max_col"},  32'(max_col),  32'd0);
        check({pfx, " max_cnt"},  32'(max_cnt),  32'd0);
        check({pfx, " area"},     32'(area),     32'd0);
    endtask

    initial begin
        int nz, idx;

        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) reset = 1'b1;

        // All-zero map: latency and the whole-map peak count.
        clear_mem();
        model();
        start_scan();
        check("zero busy_after_start", 32'(busy), 32'd1);
        check("zero res_rd_after_start", 32'(res_rd), 32'd1);
        wait_done(cyc);
        check("zero latency", 32'(cyc), 32'd16386);
        check("zero busy_at_done", 32'(busy), 32'd0);
        check_results("zero");
        check("zero cnt_const", 32'(max_cnt), 32'd16384);
        @(posedge clk);
        #1 check("zero done_low", 32'(done), 32'd0);
        check("zero done_pulses", 32'(done_pulses), 32'd1);

        // Map with three 9s and 500 non-zero pixels, used for the aborted scan and again after reset.
        clear_mem();
        mem[10*128 + 100] = 8'd9;
        mem[10*128 + 3]   = 8'd9;
        mem[120*128 + 1]  = 8'd9;
        nz = 3;
        while (nz < 500) begin
            idx = int'($urandom_range(0, 16383));
            if (mem[idx] == 8'd0) begin
                mem[idx] = 8'($urandom_range(1, 8));
                nz++;
            end
        end
        model();

        start_scan();
        repeat (99) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("abort addr_at_100", 32'(res_addr), 32'd100);
        @(posedge clk);
        #1 check("abort addr_at_101", 32'(res_addr), 32'd101);
        check("abort busy_mid", 32'(busy), 32'd1);
        repeat (7899) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_all_zero("abort");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        start_scan();
        wait_done(cyc);
        check("nine latency", 32'(cyc), 32'd16386);
        check_results("nine");
        @(posedge clk);
        #1 check("nine done_pulses", 32'(done_pulses), 32'd1);

        // Back-to-back: random map with values 0..3, then a lone 255 in the last corner.
        for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom_range(0, 3));
        model();
        start_scan();
        wait_done(cyc);
        check("rand3 latency", 32'(cyc), 32'd16386);
        check_results("rand3");
        @(posedge clk);
        #1 check("rand3 done_low", 32'(done), 32'd0);
        check("rand3 done_pulses", 32'(done_pulses), 32'd1);

        clear_mem();
        mem[16383] = 8'd255;
        model();
        start_scan();
        wait_done(cyc);
        check("corner latency", 32'(cyc), 32'd16386);
        check_results("corner");
        check("corner rd_cycles", 32'(rd_cycles), 32'd16384);
        check("corner addr_seq_err", 32'(addr_err), 32'd0);
        check("corner last_addr", 32'(prev_addr), 32'd16383);
        @(posedge clk);
        #1 check("corner done_pulses", 32'(done_pulses), 32'd1);
        check("corner res_rd_idle", 32'(res_rd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
